pid_cfg_loader: RTL
===================

// Module: pid_cfg_loader
// PURPOSE
// - Write-side initiator for the PID gain register port (write_enable/reg_addr/reg_data).
// - Takes framed config packets from a byte stream (valid/ready), checks each frame and
//   issues one register write per good frame.
// - Sits between the host byte link (UART RX or similar) and the pid block's config inputs.
// PARAMETERS
// - D_WIDTH       16     reg_addr/reg_data width; must be a multiple of 8, DB = D_WIDTH/8
// - NUM_REGS      4      valid addresses are 0..NUM_REGS-1 (kp, ki, kd_1, kd_2)
// - SYNC_BYTE     8'hA5  frame start marker
// - TIMEOUT_CYC   1000   max idle cycles between bytes inside a frame; 16-bit counter
// PORTS
// - clock         in   1        system clock, rising edge
// - reset         in   1        asynchronous, active-high
// - in_data       in   8        stream byte
// - in_valid      in   1        in_data valid
// - in_ready      out  1        loader accepts byte; transfer = in_valid & in_ready
// - write_enable  out  1        ACTIVE-LOW write strobe to the pid block
// - reg_addr      out  D_WIDTH  register address, zero-extended from frame addr byte
// - reg_data      out  D_WIDTH  register data
// - wr_count      out  8        count of good writes, wraps 255->0
// - err_pulse     out  1        one-cycle pulse on a rejected frame
// - err_code      out  2        1=checksum, 2=bad addr, 3=timeout; holds until next error
// BEHAVIOUR
// - Frame: SYNC, ADDR, DB data bytes MSB first, CSUM. CSUM = XOR of ADDR and data bytes.
// - Reset values: in_ready=0, write_enable=1, reg_addr=0, reg_data=0, wr_count=0,
//   err_pulse=0, err_code=0, FSM=HUNT, byte index=0, timeout counter=0.
// - FSM states and transitions:
//   HUNT  in_ready=1. Byte==SYNC_BYTE -> ADDR. Any other byte is dropped silently.
//   ADDR  in_ready=1. Latch addr -> DATA, byte index=0.
//   DATA  in_ready=1. Shift byte into the data shadow. After byte DB-1 -> CSUM.
//   CSUM  in_ready=1. On bad checksum -> err code 1 -> HUNT.
//         Else on addr>=NUM_REGS -> err code 2 -> HUNT.
//         Else -> WRITE. Checksum is checked before addr.
//   WRITE in_ready=0. reg_addr/reg_data are driven from the shadow, write_enable=0 for
//         exactly 1 cycle, wr_count+1 -> HUNT.
// - reg_addr/reg_data change only on entry to WRITE and hold their values afterwards.
//   A rejected frame never disturbs them.
// - Latency: CSUM byte accepted at edge N -> write_enable low during cycle N+1.
//   First byte of the next frame is accepted no earlier than edge N+2.
// - Timeout applies in ADDR, DATA and CSUM only.
//   The counter clears on each accepted byte and increments on cycles with no transfer.
//   On reaching TIMEOUT_CYC -> err code 3 -> HUNT; the partial frame is discarded.
// - SYNC_BYTE inside a frame is ordinary data; the loader does not resync mid-frame.
// - in_valid with in_ready=0 (WRITE, reset) is stalled, not dropped.
// - Reset asserted mid-frame or during WRITE: immediate return to reset values.
//   A pending write is never issued. write_enable must not glitch low on reset.
// - Error handling: err_pulse is high for the cycle after the rejecting byte edge;
//   err_code updates on that same edge.
// TESTING
// - Good frame A5 01 12 34 27 -> one cycle write_enable=0, reg_addr=1,
//   reg_data=16'h1234, wr_count=1.
// - Bad checksum A5 02 00 10 00 -> err_pulse once, err_code=1, no write,
//   reg_data unchanged.
// - Bad addr A5 07 00 01 06 (NUM_REGS=4) -> err_code=2, no write.
// - Noise 00 FF then A5 03 AB CD 65 -> leading bytes dropped, write addr 3 data ABCD.
// - Stall after A5 01 12 for TIMEOUT_CYC cycles -> err_code=3.
//   Then a full good frame is written normally.
// - Assert reset on the cycle the CSUM byte is accepted -> write_enable stays 1,
//   all outputs return to reset values.
// - Back-to-back frames with in_valid held high -> in_ready low for one cycle per write.
//   256 good frames -> wr_count wraps to 0.

Source files
------------

// File: rtl/pid_cfg_loader.sv
// ============================================================================
// pid_cfg_loader : parses SYNC/ADDR/DATA/CSUM byte frames into PID register writes
// Rev 1.0
// ============================================================================
`default_nettype none

module pid_cfg_loader #(
  parameter int unsigned D_WIDTH     = 16,
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               write_enable,
  output logic [D_WIDTH-1:0] reg_addr,
  output logic [D_WIDTH-1:0] reg_data,
  output logic [7:0]         wr_count,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  localparam int unsigned DB    = D_WIDTH / 8;
  localparam int unsigned IDX_W = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DB - 1);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         addr_q, addr_d;
  logic [D_WIDTH-1:0] shadow_q, shadow_d;
  logic [7:0]         csum_q, csum_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               in_ready_q, in_ready_d;
  logic               we_n_q, we_n_d;
  logic [D_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [D_WIDTH-1:0] reg_data_q, reg_data_d;
  logic [7:0]         wr_count_q, wr_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               xfer;

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    we_n_d      = 1'b1;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    wr_count_d  = wr_count_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      HUNT: begin
        tmo_d = '0;
        if (xfer && in_data == SYNC_BYTE) state_d = ADDR;
      end
      ADDR, DATA, CSUM: begin
        if (xfer) begin
          tmo_d = '0;
          case (state_q)
            ADDR: begin
              addr_d  = in_data;
              csum_d  = in_data;
              idx_d   = '0;
              state_d = DATA;
            end
            DATA: begin
              shadow_d = (shadow_q << 8) | D_WIDTH'(in_data);
              csum_d   = csum_q ^ in_data;
              if (idx_q == IDX_LAST) state_d = CSUM;
              else                   idx_d   = idx_q + 1'b1;
            end
            default: begin
              // Checksum is judged before the address range.
              if (in_data != csum_q) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_CSUM;
                state_d     = HUNT;
              end else if ({24'd0, addr_q} >= NUM_REGS) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_ADDR;
                state_d     = HUNT;
              end else begin
                we_n_d      = 1'b0;
                reg_addr_d  = D_WIDTH'(addr_q);
                reg_data_d  = shadow_q;
                wr_count_d  = wr_count_q + 8'd1;
                state_d     = WRITE;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          tmo_d       = '0;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TMO;
          state_d     = HUNT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        tmo_d   = '0;
        state_d = HUNT;
      end
    endcase

    // The write cycle is the only non-reset cycle that refuses bytes.
    in_ready_d = (state_d != WRITE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      addr_q      <= '0;
      shadow_q    <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      we_n_q      <= 1'b1;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      wr_count_q  <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      shadow_q    <= shadow_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      we_n_q      <= we_n_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      wr_count_q  <= wr_count_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign write_enable = we_n_q;
  assign reg_addr     = reg_addr_q;
  assign reg_data     = reg_data_q;
  assign wr_count     = wr_count_q;
  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;

endmodule

`default_nettype wire
